// File: rtl/ins_issue.sv
// Issues a host-loaded program over valid/ready; first ins_valid two edges after start, done one cycle after the final handshake.
// Backpressure: while ins_valid && !ins_ready, ins/ins_valid/pc hold; with ins_ready high it streams one per cycle.
module ins_issue #(
  parameter int ins_width = 18,
  parameter int depth     = 32,
  parameter int addr_w    = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_we,
  input  logic [addr_w-1:0]    ld_addr,
  input  logic [ins_width-1:0] ld_data,
  input  logic                 start,
  input  logic [addr_w:0]      len,
  output logic [ins_width-1:0] ins,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [addr_w:0]      pc,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [ins_width-1:0] r_mem [depth];
  logic [addr_w:0]      r_len;
  logic [addr_w:0]      r_pc;
  logic [ins_width-1:0] r_ins;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_load;

  assign w_load = !r_valid || ins_ready;

  // Store is frozen while a program runs so the issued stream matches what was loaded.
  always_ff @(posedge clk) begin
    if (ld_we && r_state != S_RUN) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_pc    <= '0;
      r_ins   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (len != '0) begin
              r_len   <= len;
              r_pc    <= '0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_load) begin
            if (r_pc < r_len) begin
              r_ins   <= r_mem[r_pc[addr_w-1:0]];
              r_valid <= 1'b1;
              r_pc    <= r_pc + 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ins       = r_ins;
  assign ins_valid = r_valid;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
